regfile_sb: RTL and testbench
=============================

# regfile_sb

Parameterised, clocked register file for the CPU datapath with two combinational read ports, a general write port, and a dedicated R0 write port for multiply/divide high-word and remainder results. Same-cycle writes are bypassed to the read ports. A per-register pending scoreboard lets the hazard unit detect reads of registers whose producer has not yet written back. The block sits between decode (reads, issue) and write-back (writes).

## Interface
- DATA_W, 16, register width in bits
- ADDR_W, 4, address width; depth = 2^ADDR_W
- USE_INIT, 1, 1 = reset loads the boot table; 0 = reset clears all registers to zero
- clk  input  1  clock; all state changes on the rising edge
- reset  input  1  synchronous, active-high reset
- rd_addr1  input  ADDR_W  read port 1 address
- rd_addr2  input  ADDR_W  read port 2 address
- rd_data1  output  DATA_W  read port 1 data (combinational)
- rd_data2  output  DATA_W  read port 2 data (combinational)
- rd_pend1  output  1  pending bit of rd_addr1 (combinational)
- rd_pend2  output  1  pending bit of rd_addr2 (combinational)
- wr_en  input  1  general write enable
- wr_addr  input  ADDR_W  general write address
- wr_data  input  DATA_W  general write data
- r0_wr_en  input  1  dedicated R0 write enable
- r0_data  input  DATA_W  dedicated R0 write data
- issue_en  input  1  instruction issued; marks its destination pending
- issue_addr  input  ADDR_W  destination of the issued instruction
- pend_count  output  ADDR_W+1  number of pending registers (registered)

## Operation
- Boot table (USE_INIT=1), R0..RF: 0000 7B18 245B FF0F F0FF 0051 6666 00FF FF88 0000 0000 3099 CCCC 0002 0011 0000.
  - For DATA_W≠16, entries are zero-extended or truncated to the low DATA_W bits.
  - Entries at index ≥16 reset to zero.
- Reset (edge with reset=1): load the table (or zeros), clear all pending bits, set pend_count=0. Write and issue inputs are ignored in that cycle.
- General write: on the edge with wr_en=1, R[wr_addr] ← wr_data.
- R0 write: on the edge with r0_wr_en=1, R[0] ← r0_data.
- Both write to R0 in the same cycle: the r0 port wins and the general write is discarded.
- Read: rd_dataN = bypass value if one applies, else R[rd_addrN].
  - Priority: r0 port (when rd_addrN=0 and r0_wr_en) > general port (when rd_addrN=wr_addr and wr_en) > array.
  - Bypass is disabled while reset=1; the array value is shown.
- Scoreboard, per register, on the edge:
  - Set pending[i] when issue_en and issue_addr=i.
  - Clear pending[i] when the register is written: wr_en with wr_addr=i, or r0_wr_en with i=0.
  - Set and clear on the same register in the same cycle: the set wins, because a newer producer has been issued.
- rd_pendN = pending[rd_addrN] AND NOT (same-cycle write to that address AND NOT same-cycle issue to it). This is the bypass-consistent view.
- pend_count equals the population count of pending after each edge. It is a registered increment/decrement, and it saturates only by construction (≤ depth).
- R0 is an ordinary writable register: it is not hardwired to zero.

## Timing
- Writes: latency 1 edge into the array, latency 0 to the read ports via bypass.
- Reads: purely combinational from addresses, array, and write inputs. No registered outputs except pend_count.
- Reset to outputs: after the reset edge, rd_data reflects the table and rd_pend=0. pend_count=0.
- Reset asserted mid-operation overrides any writes and issues in that cycle. In-flight pending state is lost.
- Pending bits and pend_count update on the same edge. There is no cycle in which they disagree.

## Test plan
- Reset, then read R1/R3 → rd_data1=7B18, rd_data2=FF0F. Read RC/RD → CCCC/0002. pend_count=0.
- wr_en, wr_addr=5, wr_data=ABCD with rd_addr1=5 in the same cycle → rd_data1=ABCD before the edge. After the edge, rd_data1=ABCD with wr_en=0.
- wr_en to addr 0 with 1111, and r0_wr_en with 2222, in the same cycle → rd_data1(addr 0)=2222 combinationally and after the edge.
- issue addr 7 → next cycle rd_pend1(7)=1, pend_count=1. Write addr 7 with 0042 → rd_pend1=0 in the write cycle. After the edge, pend_count=0 and data=0042.
- issue and write addr 3 in the same cycle → after the edge pending[3]=1, R3=written value, pend_count unchanged from +1.
- Issue 3 registers, then assert reset together with wr_en to R2=FFFF → R2=245B, all pending=0, pend_count=0.

Source files
------------

// File: rtl/regfile_sb.sv
// Register file with two bypassed combinational read ports, a general and a
// dedicated R0 write port, and a per-register pending scoreboard with count.
module regfile_sb #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 4,
    parameter bit USE_INIT = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2,
    output logic              rd_pend1,
    output logic              rd_pend2,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              r0_wr_en,
    input  logic [DATA_W-1:0] r0_data,
    input  logic              issue_en,
    input  logic [ADDR_W-1:0] issue_addr,
    output logic [ADDR_W:0]   pend_count
);
    localparam int DEPTH = 1 << ADDR_W;

    // Boot contents; entries beyond the table and width mismatches resolve to
    // zero-extension / truncation of the 16-bit constants.
    function automatic logic [DATA_W-1:0] boot_val(input int idx);
        logic [15:0] v;
        case (idx)
            1:       v = 16'h7B18;
            2:       v = 16'h245B;
            3:       v = 16'hFF0F;
            4:       v = 16'hF0FF;
            5:       v = 16'h0051;
            6:       v = 16'h6666;
            7:       v = 16'h00FF;
            8:       v = 16'hFF88;
            11:      v = 16'h3099;
            12:      v = 16'hCCCC;
            13:      v = 16'h0002;
            14:      v = 16'h0011;
            default: v = 16'h0000;
        endcase
        return DATA_W'(v);
    endfunction

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  pend_reg;
    logic [DEPTH-1:0]  pend_next;
    logic [ADDR_W:0]   pend_count_reg;
    logic [ADDR_W:0]   set_cnt;
    logic [ADDR_W:0]   clr_cnt;
    logic              gen_wr_ok;

    // A general write to R0 loses against the dedicated R0 port.
    assign gen_wr_ok = wr_en && !(r0_wr_en && (wr_addr == '0));

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= USE_INIT ? boot_val(i) : '0;
            end
            pend_reg       <= '0;
            pend_count_reg <= '0;
        end else begin
            if (gen_wr_ok) begin
                regs[wr_addr] <= wr_data;
            end
            if (r0_wr_en) begin
                regs[0] <= r0_data;
            end
            pend_reg       <= pend_next;
            pend_count_reg <= pend_count_reg + set_cnt - clr_cnt;
        end
    end

    // Issue beats write-back on the same register: a newer producer exists.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_pend
            logic is_issue;
            logic is_write;
            assign is_issue     = issue_en && (issue_addr == ADDR_W'(gi));
            assign is_write     = (wr_en && (wr_addr == ADDR_W'(gi))) || ((gi == 0) && r0_wr_en);
            assign pend_next[gi] = is_issue || (pend_reg[gi] && !is_write);
        end
    endgenerate

    always_comb begin
        set_cnt = '0;
        clr_cnt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            set_cnt = set_cnt + {{ADDR_W{1'b0}}, pend_next[i] & ~pend_reg[i]};
            clr_cnt = clr_cnt + {{ADDR_W{1'b0}}, pend_reg[i] & ~pend_next[i]};
        end
    end

    assign pend_count = pend_count_reg;

    generate
        for (gi = 0; gi < 2; gi++) begin : g_rd
            logic [ADDR_W-1:0] addr;
            logic [DATA_W-1:0] data;
            logic              pend;
            logic              hit_r0;
            logic              hit_wr;
            logic              hit_issue;

            assign addr = (gi == 0) ? rd_addr1 : rd_addr2;

            always_comb begin
                hit_r0    = r0_wr_en && (addr == '0);
                hit_wr    = wr_en && (addr == wr_addr);
                hit_issue = issue_en && (addr == issue_addr);
                data      = regs[addr];
                if (!reset) begin
                    if (hit_r0) begin
                        data = r0_data;
                    end else if (hit_wr) begin
                        data = wr_data;
                    end
                end
                pend = pend_reg[addr] && !((hit_r0 || hit_wr) && !hit_issue);
            end
        end
    endgenerate

    assign rd_data1 = g_rd[0].data;
    assign rd_data2 = g_rd[1].data;
    assign rd_pend1 = g_rd[0].pend;
    assign rd_pend2 = g_rd[1].pend;
endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: reset table, bypass priority, scoreboard and count.
module tb_regfile_sb;
    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  rd_addr1, rd_addr2;
    logic [15:0] rd_data1, rd_data2;
    logic        rd_pend1, rd_pend2;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [15:0] wr_data;
    logic        r0_wr_en;
    logic [15:0] r0_data;
    logic        issue_en;
    logic [3:0]  issue_addr;
    logic [4:0]  pend_count;

    int checks = 0;
    int errors = 0;

    regfile_sb #(.DATA_W(16), .ADDR_W(4), .USE_INIT(1'b1)) dut (
        .clk(clk), .reset(reset),
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .rd_data1(rd_data1), .rd_data2(rd_data2),
        .rd_pend1(rd_pend1), .rd_pend2(rd_pend2),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .r0_wr_en(r0_wr_en), .r0_data(r0_data),
        .issue_en(issue_en), .issue_addr(issue_addr),
        .pend_count(pend_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
        $display("check %-16s observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en = 1'b0; r0_wr_en = 1'b0; issue_en = 1'b0; reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        r0_wr_en = 1'b0; r0_data = '0; issue_en = 1'b0; issue_addr = '0;
        rd_addr1 = '0; rd_addr2 = '0;
        tick();
        idle();

        // Reset table
        rd_addr1 = 4'h1; rd_addr2 = 4'h3; #1;
        check("rst_r1", rd_data1, 16'h7B18);
        check("rst_r3", rd_data2, 16'hFF0F);
        rd_addr1 = 4'hC; rd_addr2 = 4'hD; #1;
        check("rst_rc", rd_data1, 16'hCCCC);
        check("rst_rd", rd_data2, 16'h0002);
        check("rst_pcnt", pend_count, 5'd0);
        check("rst_pend", {rd_pend1, rd_pend2}, 2'b00);

        // General write bypass and commit
        wr_en = 1'b1; wr_addr = 4'h5; wr_data = 16'hABCD; rd_addr1 = 4'h5; rd_addr2 = 4'h6; #1;
        check("byp_w5", rd_data1, 16'hABCD);
        check("nobyp_r6", rd_data2, 16'h6666);
        tick();
        idle(); #1;
        check("commit_w5", rd_data1, 16'hABCD);

        // R0 port beats general port; general write to another address still bypasses
        wr_en = 1'b1; wr_addr = 4'h0; wr_data = 16'h1111;
        r0_wr_en = 1'b1; r0_data = 16'h2222; rd_addr1 = 4'h0; #1;
        check("byp_r0_prio", rd_data1, 16'h2222);
        tick();
        idle(); #1;
        check("commit_r0", rd_data1, 16'h2222);
        wr_en = 1'b1; wr_addr = 4'h4; wr_data = 16'h4444;
        r0_wr_en = 1'b1; r0_data = 16'h5555; rd_addr1 = 4'h4; rd_addr2 = 4'h0; #1;
        check("byp_w4_both", rd_data1, 16'h4444);
        check("byp_r0_both", rd_data2, 16'h5555);
        tick();
        idle();

        // Issue then write-back of R7
        issue_en = 1'b1; issue_addr = 4'h7; tick();
        idle(); rd_addr1 = 4'h7; #1;
        check("pend7", rd_pend1, 1'b1);
        check("pcnt_1", pend_count, 5'd1);
        wr_en = 1'b1; wr_addr = 4'h7; wr_data = 16'h0042; #1;
        check("pend7_wcyc", rd_pend1, 1'b0);
        check("byp_w7", rd_data1, 16'h0042);
        tick();
        idle(); #1;
        check("pcnt_0", pend_count, 5'd0);
        check("r7_data", rd_data1, 16'h0042);
        check("pend7_clr", rd_pend1, 1'b0);

        // Same-cycle issue and write of R3: set wins
        issue_en = 1'b1; issue_addr = 4'h3; wr_en = 1'b1; wr_addr = 4'h3; wr_data = 16'h1357;
        rd_addr1 = 4'h3; #1;
        check("pend3_iw", rd_pend1, 1'b0);
        tick();
        idle(); #1;
        check("pend3_set", rd_pend1, 1'b1);
        check("r3_data", rd_data1, 16'h1357);
        check("pcnt_iw", pend_count, 5'd1);

        // R0: general and r0 writes both clear one pending bit exactly once
        issue_en = 1'b1; issue_addr = 4'h0; tick();
        idle(); rd_addr2 = 4'h0; #1;
        check("pcnt_r0iss", pend_count, 5'd2);
        check("pend0", rd_pend2, 1'b1);
        wr_en = 1'b1; wr_addr = 4'h0; wr_data = 16'h0BAD; r0_wr_en = 1'b1; r0_data = 16'h600D; #1;
        check("pend0_wcyc", rd_pend2, 1'b0);
        tick();
        idle(); #1;
        check("pcnt_r0clr", pend_count, 5'd1);
        check("r0_data", rd_data2, 16'h600D);

        // Three more issues, then reset with a competing write
        issue_en = 1'b1; issue_addr = 4'h8; tick();
        issue_addr = 4'h9; tick();
        issue_addr = 4'hA; tick();
        idle(); #1;
        check("pcnt_4", pend_count, 5'd4);
        reset = 1'b1; wr_en = 1'b1; wr_addr = 4'h2; wr_data = 16'hFFFF;
        issue_en = 1'b1; issue_addr = 4'hB; rd_addr1 = 4'h2; #1;
        check("rst_nobyp", rd_data1, 16'h245B);
        tick();
        idle(); rd_addr1 = 4'h2; rd_addr2 = 4'h8; #1;
        check("rst2_r2", rd_data1, 16'h245B);
        check("rst2_pend8", rd_pend2, 1'b0);
        check("rst2_pcnt", pend_count, 5'd0);
        rd_addr1 = 4'h5; rd_addr2 = 4'h0; #1;
        check("rst2_r5", rd_data1, 16'h0051);
        check("rst2_r0", rd_data2, 16'h0000);
        rd_addr1 = 4'hB; #1;
        check("rst2_pendb", rd_pend1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
